ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single external RAM port (ram_async request/done interface) between the CPU path
//  (bus unit, after the MMU) and a DMA master, e.g. the RK/IDE disk controller.
//  Sits between the bus and ram_async: it serialises cycles, routes data both ways and
//  enforces DMA priority with a CPU-fairness limit.
//  A watchdog aborts any cycle that ram_async never completes.
// PARAMETERS
//  DMA_BURST  4     max back-to-back DMA grants while CPU is requesting (1..15)
//  TIMEOUT    255   clk cycles without ram_done before a cycle is aborted (8-bit counter)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-high reset
//  cpu_addr      in   22  CPU physical address
//  cpu_wdata     in   16  CPU write data
//  cpu_rd/cpu_wr in   1   CPU level requests, held until cpu_done
//  cpu_byte_op   in   1   CPU byte transfer
//  cpu_rdata     out  16  read data, valid while cpu_done=1
//  cpu_done      out  1   one-cycle completion pulse
//  cpu_err       out  1   one-cycle pulse with cpu_done on timeout
//  dma_*         -    -   identical set: dma_addr, dma_wdata, dma_rd, dma_wr, dma_byte_op,
//                         dma_rdata, dma_done, dma_err
//  ram_addr      out  22  to ram_async
//  ram_wdata     out  16  to ram_async data_in
//  ram_rdata     in   16  from ram_async data_out
//  ram_rd/ram_wr out  1   RAM strobes
//  ram_byte_op   out  1   RAM byte transfer
//  ram_done      in   1   RAM completion
//  owner         out  2   00 none, 01 CPU, 10 DMA (debug/LED)
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, burst count 0, watchdog 0. Reset asserted mid-cycle
//  drops ram_rd/ram_wr at once (async); the interrupted requester receives no done.
//  FSM IDLE -> CPU_CYC | DMA_CYC -> RECOVER -> IDLE.
//  IDLE: request = rd|wr. Both request: DMA wins unless burst_cnt==DMA_BURST, then CPU wins.
//    On entry the winner's addr, wdata, byte_op, rd, wr are latched; they are held stable
//    for the whole cycle even if the requester changes its inputs.
//  rd and wr both asserted: treated as a write (ram_rd=0).
//  CPU_CYC/DMA_CYC: registered ram strobes asserted from the first cycle of the state.
//    On ram_done=1: latch ram_rdata into *_rdata, pulse the owner's *_done next cycle,
//    go to RECOVER.
//  RECOVER: strobes deasserted for exactly 1 cycle (ram_async needs the edge), owner=00.
//    The requester must drop rd/wr in this cycle; a still-held request is granted again.
//  Latency: request seen in IDLE at cycle N, strobes at N+1, ram_done at M gives *_done at
//    M+1 and IDLE at M+2. Minimum 3 cycles per transfer.
//  burst_cnt: +1 per DMA grant while cpu request pending, saturates at DMA_BURST;
//    cleared on any CPU grant and whenever the CPU is not requesting.
//  Watchdog: counts cycles in *_CYC, cleared on entry. At TIMEOUT: strobes drop, owner gets
//    done+err (rdata=0), go to RECOVER. ram_done in the same cycle as the timeout: done
//    wins, no err.
//  *_rdata holds its value between cycles; writes do not modify it.
//  Requester dropping its request mid-cycle: the cycle completes and done is still pulsed.
// STRUCTURE
//  pdp11_bus_pkg (shared): OWNER_NONE/CPU/DMA codes, ARB_IDLE/CPU_CYC/DMA_CYC/RECOVER
//    state encodings, PA_WIDTH=22.
//  Sub-module arb_watchdog: clear/enable/expire counter, parameter TIMEOUT; used here and
//    reusable by the bus unit.
//  Remainder (FSM, request latch, burst counter, muxing) stays flat in ram_arbiter.
// TESTING
//  1 CPU read @22'o173000, ram_done after 2 cycles with 16'o012706 -> ram_rd 1 cycle after
//    request; cpu_done 1 cycle after ram_done with cpu_rdata=16'o012706; RECOVER strobes 0.
//  2 CPU and DMA request the same cycle -> DMA granted first; CPU served after RECOVER;
//    owner sequence 10,00,01.
//  3 DMA held continuously, CPU continuously requesting, DMA_BURST=4 -> grant pattern
//    D D D D C D D D D C ...
//  4 DMA write, ram_done never asserted, TIMEOUT=255 -> dma_done+dma_err exactly 256 cycles
//    after strobe; ram_wr low next cycle.
//  5 Reset pulsed 3 cycles into a CPU write -> ram_wr=0 immediately; no cpu_done; next
//    request served normally.
//  6 CPU byte write with rd=wr=1, byte_op=1, then cpu_addr changed mid-cycle -> ram_wr=1,
//    ram_rd=0, ram_byte_op=1, ram_addr keeps the original address.

Source files
------------

// File: rtl/pdp11_bus_pkg.sv
// Shared bus definitions: physical address width, RAM port owner codes and
// the ram_arbiter state encoding.
package pdp11_bus_pkg;

  localparam int unsigned PaWidth = 22;

  // Owner codes as seen on the debug/LED output
  localparam logic [1:0] OwnerNone = 2'b00;
  localparam logic [1:0] OwnerCpu  = 2'b01;
  localparam logic [1:0] OwnerDma  = 2'b10;

  typedef enum logic [1:0] {
    ArbIdle    = 2'b00,
    ArbCpuCyc  = 2'b01,
    ArbDmaCyc  = 2'b10,
    ArbRecover = 2'b11
  } arb_state_e;

endpackage

// File: rtl/arb_watchdog.sv
// Cycle watchdog: counts enabled cycles and flags expiry once TIMEOUT cycles
// have elapsed since the last clear.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   clear       zero the counter (takes priority over enable)
//   enable      count this cycle
//   expired     counter has reached TIMEOUT while enabled
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] Limit = 8'(TIMEOUT);

  logic [7:0] cnt_q;

  assign expired = enable && (cnt_q == Limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single ram_async port between the CPU path and a DMA master.
// One cycle at a time; DMA has priority but the CPU wins after DMA_BURST
// consecutive DMA grants while it is waiting. A watchdog aborts cycles that
// never see ram_done.
// Ports:
//   clk, reset                  system clock, asynchronous active-high reset
//   cpu_* / dma_*               requester side: addr, wdata, rd, wr, byte_op in;
//                               rdata, done (1-cycle pulse), err (pulse on timeout) out
//   ram_addr/wdata/rd/wr/byte_op  to ram_async (registered)
//   ram_rdata, ram_done          from ram_async
//   owner                       00 none, 01 CPU, 10 DMA
module ram_arbiter
  import pdp11_bus_pkg::*;
#(
  parameter int unsigned DMA_BURST = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PaWidth-1:0] cpu_addr,
  input  logic [15:0]        cpu_wdata,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  input  logic               cpu_byte_op,
  output logic [15:0]        cpu_rdata,
  output logic               cpu_done,
  output logic               cpu_err,
  input  logic [PaWidth-1:0] dma_addr,
  input  logic [15:0]        dma_wdata,
  input  logic               dma_rd,
  input  logic               dma_wr,
  input  logic               dma_byte_op,
  output logic [15:0]        dma_rdata,
  output logic               dma_done,
  output logic               dma_err,
  output logic [PaWidth-1:0] ram_addr,
  output logic [15:0]        ram_wdata,
  input  logic [15:0]        ram_rdata,
  output logic               ram_rd,
  output logic               ram_wr,
  output logic               ram_byte_op,
  input  logic               ram_done,
  output logic [1:0]         owner
);

  localparam logic [3:0] BurstMax = 4'(DMA_BURST);

  arb_state_e         state_q, state_d;
  logic [3:0]         burst_q;
  logic [PaWidth-1:0] addr_q;
  logic [15:0]        wdata_q, cpu_rdata_q, dma_rdata_q;
  logic               byte_q, rd_q, wr_q;
  logic               cpu_done_q, cpu_err_q, dma_done_q, dma_err_q;
  logic               cpu_req, dma_req, cpu_wins, grant_cpu, grant_dma;
  logic               in_cyc, expired, cyc_end;

  assign cpu_req   = cpu_rd | cpu_wr;
  assign dma_req   = dma_rd | dma_wr;
  assign cpu_wins  = cpu_req && (!dma_req || (burst_q == BurstMax));
  assign grant_cpu = (state_q == ArbIdle) && cpu_wins;
  assign grant_dma = (state_q == ArbIdle) && dma_req && !cpu_wins;
  assign in_cyc    = (state_q == ArbCpuCyc) || (state_q == ArbDmaCyc);
  assign cyc_end   = in_cyc && (ram_done || expired);

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_cyc),
    .enable (in_cyc),
    .expired(expired)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ArbIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ArbIdle: begin
        if (grant_dma) begin
          state_d = ArbDmaCyc;
        end else if (grant_cpu) begin
          state_d = ArbCpuCyc;
        end
      end
      ArbCpuCyc, ArbDmaCyc: begin
        if (ram_done || expired) begin
          state_d = ArbRecover;
        end
      end
      ArbRecover: state_d = ArbIdle;
      default:    state_d = ArbIdle;
    endcase
  end

  // Output decode
  always_comb begin
    owner = OwnerNone;
    unique case (state_q)
      ArbCpuCyc: owner = OwnerCpu;
      ArbDmaCyc: owner = OwnerDma;
      default:   owner = OwnerNone;
    endcase
  end

  // Request latch; the strobes are registered so they rise with the first cycle
  // of *_CYC and fall on the edge that enters RECOVER.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      byte_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (grant_cpu) begin
      addr_q  <= cpu_addr;
      wdata_q <= cpu_wdata;
      byte_q  <= cpu_byte_op;
      rd_q    <= cpu_rd & ~cpu_wr;  // rd+wr together is a write
      wr_q    <= cpu_wr;
    end else if (grant_dma) begin
      addr_q  <= dma_addr;
      wdata_q <= dma_wdata;
      byte_q  <= dma_byte_op;
      rd_q    <= dma_rd & ~dma_wr;
      wr_q    <= dma_wr;
    end else if (cyc_end) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end
  end

  // Completion pulses and read data; ram_done beats a simultaneous timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      dma_done_q  <= 1'b0;
      dma_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cpu_done_q <= cyc_end && (state_q == ArbCpuCyc);
      cpu_err_q  <= cyc_end && (state_q == ArbCpuCyc) && !ram_done;
      dma_done_q <= cyc_end && (state_q == ArbDmaCyc);
      dma_err_q  <= cyc_end && (state_q == ArbDmaCyc) && !ram_done;
      if (cyc_end && rd_q) begin
        if (state_q == ArbCpuCyc) begin
          cpu_rdata_q <= ram_done ? ram_rdata : 16'h0000;
        end else begin
          dma_rdata_q <= ram_done ? ram_rdata : 16'h0000;
        end
      end
    end
  end

  // Consecutive DMA grants while the CPU waits; any CPU grant or idle CPU resets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_q <= '0;
    end else if (!cpu_req || grant_cpu) begin
      burst_q <= '0;
    end else if (grant_dma && (burst_q < BurstMax)) begin
      burst_q <= burst_q + 4'd1;
    end
  end

  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign ram_byte_op = byte_q;
  assign ram_rd      = rd_q;
  assign ram_wr      = wr_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_done    = cpu_done_q;
  assign cpu_err     = cpu_err_q;
  assign dma_rdata   = dma_rdata_q;
  assign dma_done    = dma_done_q;
  assign dma_err     = dma_err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios plus randomized single-requester
// transfers checked against a memory-level reference model.
module tb_ram_arbiter;

  localparam int unsigned DmaBurst = 4;
  localparam int unsigned Timeout  = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [21:0] cpu_addr, dma_addr, ram_addr;
  logic [15:0] cpu_wdata, dma_wdata, ram_wdata;
  logic [15:0] cpu_rdata, dma_rdata, ram_rdata;
  logic        cpu_rd, cpu_wr, cpu_byte_op, cpu_done, cpu_err;
  logic        dma_rd, dma_wr, dma_byte_op, dma_done, dma_err;
  logic        ram_rd, ram_wr, ram_byte_op, ram_done;
  logic [1:0]  owner;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .DMA_BURST(DmaBurst),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_byte_op(cpu_byte_op),
    .cpu_rdata  (cpu_rdata),
    .cpu_done   (cpu_done),
    .cpu_err    (cpu_err),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_rd     (dma_rd),
    .dma_wr     (dma_wr),
    .dma_byte_op(dma_byte_op),
    .dma_rdata  (dma_rdata),
    .dma_done   (dma_done),
    .dma_err    (dma_err),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_rd     (ram_rd),
    .ram_wr     (ram_wr),
    .ram_byte_op(ram_byte_op),
    .ram_done   (ram_done),
    .owner      (owner)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_byte_op = 1'b0;
    dma_rd = 1'b0; dma_wr = 1'b0; dma_byte_op = 1'b0;
    ram_done = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    cpu_addr = 22'($urandom); dma_addr = 22'($urandom);
    cpu_wdata = 16'($urandom); dma_wdata = 16'($urandom); ram_rdata = 16'($urandom);
    reset = 1'b1;
    step(); step();
    checks++;
    if ({ram_rd, ram_wr, ram_byte_op, cpu_done, cpu_err, dma_done, dma_err, owner} !== 9'h0)
      begin failures++; $display("FAIL reset_ctrl: got %b expected 0",
        {ram_rd, ram_wr, ram_byte_op, cpu_done, cpu_err, dma_done, dma_err, owner}); end
    checks++;
    if ({ram_addr, ram_wdata, cpu_rdata, dma_rdata} !== 70'h0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wdata=%h crd=%h drd=%h expected 0",
               ram_addr, ram_wdata, cpu_rdata, dma_rdata);
    end
    reset = 1'b0;
    step();
    checks++;
    if (owner !== 2'b00 || ram_rd !== 1'b0) begin
      failures++; $display("FAIL reset_idle: got owner=%b rd=%b expected 00/0", owner, ram_rd);
    end
  endtask

  task automatic test_cpu_read();
    cpu_addr = 22'o173000; cpu_rd = 1'b1;
    step();
    checks++;
    if (ram_rd !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== 22'o173000 || owner !== 2'b01) begin
      failures++;
      $display("FAIL cpu_read_strobe: got rd=%b wr=%b addr=%o owner=%b expected 1/0/173000/01",
               ram_rd, ram_wr, ram_addr, owner);
    end
    step();
    checks++;
    if (ram_rd !== 1'b1 || cpu_done !== 1'b0) begin
      failures++; $display("FAIL cpu_read_wait: got rd=%b done=%b expected 1/0", ram_rd, cpu_done);
    end
    ram_done = 1'b1; ram_rdata = 16'o012706;
    step();
    ram_done = 1'b0; cpu_rd = 1'b0; ram_rdata = 16'($urandom);
    checks++;
    if (cpu_done !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 16'o012706) begin
      failures++;
      $display("FAIL cpu_read_done: got done=%b err=%b rdata=%o expected 1/0/012706",
               cpu_done, cpu_err, cpu_rdata);
    end
    checks++;
    if (ram_rd !== 1'b0 || ram_wr !== 1'b0 || owner !== 2'b00) begin
      failures++; $display("FAIL cpu_read_recover: got rd=%b wr=%b owner=%b expected 0/0/00",
                           ram_rd, ram_wr, owner);
    end
    step();
    checks++;
    if (cpu_done !== 1'b0 || cpu_rdata !== 16'o012706) begin
      failures++; $display("FAIL cpu_read_hold: got done=%b rdata=%o expected 0/012706",
                           cpu_done, cpu_rdata);
    end
  endtask

  task automatic test_priority();
    logic [21:0] a_cpu, a_dma;
    logic [15:0] w_dma, r_cpu;
    int          waited;
    a_cpu = 22'($urandom); a_dma = 22'($urandom); w_dma = 16'($urandom); r_cpu = 16'($urandom);
    cpu_addr = a_cpu; cpu_rd = 1'b1;
    dma_addr = a_dma; dma_wdata = w_dma; dma_wr = 1'b1;
    step();
    checks++;
    if (owner !== 2'b10 || ram_wr !== 1'b1 || ram_addr !== a_dma || ram_wdata !== w_dma) begin
      failures++; $display("FAIL prio_dma_first: got owner=%b wr=%b addr=%h expected 10/1/%h",
                           owner, ram_wr, ram_addr, a_dma);
    end
    ram_done = 1'b1;
    step();
    ram_done = 1'b0; dma_wr = 1'b0;
    checks++;
    if (owner !== 2'b00 || dma_done !== 1'b1 || cpu_done !== 1'b0 || ram_wr !== 1'b0) begin
      failures++; $display("FAIL prio_recover: got owner=%b ddone=%b cdone=%b expected 00/1/0",
                           owner, dma_done, cpu_done);
    end
    waited = 0;
    while (owner === 2'b00 && waited < 4) begin
      step();
      waited++;
    end
    checks++;
    if (owner !== 2'b01 || ram_rd !== 1'b1 || ram_addr !== a_cpu || waited != 2) begin
      failures++; $display("FAIL prio_cpu_next: got owner=%b addr=%h after %0d expected 01/%h after 2",
                           owner, ram_addr, waited, a_cpu);
    end
    ram_done = 1'b1; ram_rdata = r_cpu;
    step();
    ram_done = 1'b0; cpu_rd = 1'b0;
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== r_cpu) begin
      failures++; $display("FAIL prio_cpu_done: got done=%b rdata=%h expected 1/%h",
                           cpu_done, cpu_rdata, r_cpu);
    end
    step();
  endtask

  task automatic test_burst();
    int         streak, grants;
    logic [1:0] prev_owner, exp_owner;
    streak = 0; grants = 0; prev_owner = 2'b00;
    cpu_rd = 1'b1; dma_rd = 1'b1;
    for (int i = 0; i < 200 && grants < 15; i++) begin
      step();
      ram_done = (owner != 2'b00);
      if (owner != 2'b00 && prev_owner == 2'b00) begin
        // Rule: DMA unless it already won DmaBurst times in a row with the CPU waiting
        if (streak == DmaBurst) begin exp_owner = 2'b01; streak = 0; end
        else begin exp_owner = 2'b10; streak++; end
        checks++;
        if (owner !== exp_owner) begin
          failures++; $display("FAIL burst_grant_%0d: got %b expected %b", grants, owner, exp_owner);
        end
        grants++;
      end
      prev_owner = owner;
    end
    checks++;
    if (grants != 15) begin
      failures++; $display("FAIL burst_grant_count: got %0d expected 15", grants);
    end
    cpu_rd = 1'b0; dma_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      ram_done = (owner != 2'b00);
    end
    ram_done = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    dma_addr = 22'($urandom); dma_wdata = 16'($urandom); dma_wr = 1'b1;
    step();
    dma_wr = 1'b0;
    checks++;
    if (ram_wr !== 1'b1) begin
      failures++; $display("FAIL timeout_strobe: got wr=%b expected 1", ram_wr);
    end
    n = 0;
    while (dma_done !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n != 256) begin
      failures++; $display("FAIL timeout_latency: got %0d cycles expected 256", n);
    end
    checks++;
    if (dma_err !== 1'b1 || ram_wr !== 1'b0 || owner !== 2'b00) begin
      failures++; $display("FAIL timeout_abort: got err=%b wr=%b owner=%b expected 1/0/00",
                           dma_err, ram_wr, owner);
    end
    step();
    checks++;
    if (dma_done !== 1'b0 || dma_err !== 1'b0 || ram_wr !== 1'b0) begin
      failures++; $display("FAIL timeout_after: got done=%b err=%b wr=%b expected 0/0/0",
                           dma_done, dma_err, ram_wr);
    end
  endtask

  task automatic test_reset_mid();
    int          dones;
    logic [15:0] r;
    cpu_addr = 22'($urandom); cpu_wdata = 16'($urandom); cpu_wr = 1'b1;
    step();
    checks++;
    if (ram_wr !== 1'b1) begin
      failures++; $display("FAIL rstmid_strobe: got wr=%b expected 1", ram_wr);
    end
    step(); step();
    reset = 1'b1;
    #1;
    checks++;
    if (ram_wr !== 1'b0 || owner !== 2'b00) begin
      failures++; $display("FAIL rstmid_async: got wr=%b owner=%b expected 0/00", ram_wr, owner);
    end
    cpu_wr = 1'b0;
    step();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (cpu_done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++; $display("FAIL rstmid_nodone: got %0d done pulses expected 0", dones);
    end
    r = 16'($urandom);
    cpu_addr = 22'($urandom); cpu_rd = 1'b1;
    step();
    ram_done = 1'b1; ram_rdata = r;
    step();
    ram_done = 1'b0; cpu_rd = 1'b0;
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== r) begin
      failures++; $display("FAIL rstmid_resume: got done=%b rdata=%h expected 1/%h",
                           cpu_done, cpu_rdata, r);
    end
    step();
  endtask

  // Runs right after test_reset_mid, so cpu_rdata must still hold that read.
  task automatic test_byte_write(input logic [15:0] held);
    logic [21:0] a;
    logic [15:0] w;
    a = 22'($urandom); w = 16'($urandom);
    cpu_addr = a; cpu_wdata = w; cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_byte_op = 1'b1;
    step();
    checks++;
    if ({ram_wr, ram_rd, ram_byte_op} !== 3'b101 || ram_addr !== a || ram_wdata !== w) begin
      failures++; $display("FAIL byte_strobe: got wr/rd/byte=%b addr=%h expected 101/%h",
                           {ram_wr, ram_rd, ram_byte_op}, ram_addr, a);
    end
    cpu_addr = ~a; cpu_byte_op = 1'b0; cpu_wdata = ~w;
    step();
    checks++;
    if ({ram_wr, ram_rd, ram_byte_op} !== 3'b101 || ram_addr !== a || ram_wdata !== w) begin
      failures++; $display("FAIL byte_stable: got wr/rd/byte=%b addr=%h wdata=%h expected 101/%h/%h",
                           {ram_wr, ram_rd, ram_byte_op}, ram_addr, ram_wdata, a, w);
    end
    ram_done = 1'b1; ram_rdata = 16'($urandom);
    step();
    ram_done = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_byte_op = 1'b0;
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== held) begin
      failures++; $display("FAIL byte_done: got done=%b rdata=%h expected 1/%h",
                           cpu_done, cpu_rdata, held);
    end
    step();
  endtask

  task automatic test_random();
    logic [15:0] ram_mem [8];
    logic [15:0] ref_mem [8];
    logic [15:0] hold [2];
    bit          known [2];
    bit          is_dma, is_wr, both;
    logic [2:0]  idx;
    logic [21:0] addr;
    logic [15:0] wd, got_rdata;
    logic        bop, got_done, got_err, other_done;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      ram_mem[i] = 16'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    known[0] = 1'b0; known[1] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      is_dma = 1'($urandom); is_wr = 1'($urandom); both = is_wr && ($urandom_range(0, 3) == 0);
      idx = 3'($urandom); addr = {19'($urandom), idx}; wd = 16'($urandom);
      bop = 1'($urandom); lat = $urandom_range(0, 3);
      if (is_dma) begin
        dma_addr = addr; dma_wdata = wd; dma_byte_op = bop; dma_wr = is_wr; dma_rd = !is_wr || both;
      end else begin
        cpu_addr = addr; cpu_wdata = wd; cpu_byte_op = bop; cpu_wr = is_wr; cpu_rd = !is_wr || both;
      end
      step();
      checks++;
      if (owner !== (is_dma ? 2'b10 : 2'b01) || ram_addr !== addr || ram_byte_op !== bop ||
          ram_wr !== is_wr || ram_rd !== !is_wr || (is_wr && ram_wdata !== wd)) begin
        failures++;
        $display("FAIL rand_%0d_issue: got owner=%b addr=%h wr=%b rd=%b byte=%b expected dma=%0d %h wr=%b",
                 t, owner, ram_addr, ram_wr, ram_rd, ram_byte_op, is_dma, addr, is_wr);
      end
      // Requester scrambles its inputs and may drop the request mid-cycle.
      cpu_addr = 22'($urandom); dma_addr = 22'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        cpu_rd = 1'b0; cpu_wr = 1'b0; dma_rd = 1'b0; dma_wr = 1'b0;
      end
      for (int k = 0; k < lat; k++) step();
      ram_rdata = ram_mem[ram_addr[2:0]];
      if (ram_wr) ram_mem[ram_addr[2:0]] = ram_wdata;
      ram_done = 1'b1;
      step();
      ram_done = 1'b0;
      cpu_rd = 1'b0; cpu_wr = 1'b0; dma_rd = 1'b0; dma_wr = 1'b0;
      got_done   = is_dma ? dma_done : cpu_done;
      got_err    = is_dma ? dma_err : cpu_err;
      got_rdata  = is_dma ? dma_rdata : cpu_rdata;
      other_done = is_dma ? cpu_done : dma_done;
      checks++;
      if (got_done !== 1'b1 || got_err !== 1'b0 || other_done !== 1'b0) begin
        failures++; $display("FAIL rand_%0d_done: got done=%b err=%b other=%b expected 1/0/0",
                             t, got_done, got_err, other_done);
      end
      if (!is_wr) begin
        checks++;
        if (got_rdata !== ref_mem[idx]) begin
          failures++; $display("FAIL rand_%0d_rdata: got %h expected %h", t, got_rdata, ref_mem[idx]);
        end
        hold[is_dma] = ref_mem[idx];
        known[is_dma] = 1'b1;
      end else begin
        ref_mem[idx] = wd;
        if (known[is_dma]) begin
          checks++;
          if (got_rdata !== hold[is_dma]) begin
            failures++; $display("FAIL rand_%0d_hold: got %h expected %h", t, got_rdata, hold[is_dma]);
          end
        end
      end
      step();
    end
  endtask

  logic [15:0] rstmid_read;

  initial begin
    reset = 1'b1;
    test_reset();
    test_cpu_read();
    test_priority();
    test_burst();
    test_timeout();
    test_reset_mid();
    rstmid_read = ram_rdata;  // value the bench itself returned for the last CPU read
    test_byte_write(rstmid_read);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
